usbfs_ctrl_responder: RTL and testbench
=======================================

// Module: usbfs_ctrl_responder
// PURPOSE
//  Device-side responder for USB full-speed control endpoint 0. Decodes 8B SETUP
//  payloads, serves GET_DESCRIPTOR data in MAX_PKT chunks from a descriptor ROM,
//  and runs the status stages. Applies SET_ADDRESS and SET_CONFIGURATION.
//  Sits between the device packet transactor and the device's EP0 logic.
//  Counterpart of the host-side control transfer driver.
// PARAMETERS
//  MAX_PKT       8    EP0 max packet size, bytes (power of 2)
//  ROM_AW        7    descriptor ROM address width
//  DEVDESC_BASE  0    ROM byte address of device descriptor
//  DEVDESC_LEN   18   device descriptor length, bytes
//  CFGDESC_BASE  18   ROM byte address of config descriptor
//  CFGDESC_LEN   32   total config descriptor length, bytes
// PORTS
//  i_clk             in   1                    clock
//  i_rst             in   1                    reset, asynchronous, active-high
//  i_setupValid      in   1                    SETUP payload received and ACKed by transactor
//  i_setupData       in   64                   SETUP payload, byte0 in [7:0]
//  i_tknValid        in   1                    EP0 IN/OUT token pending
//  o_tknReady        out  1                    token accepted
//  i_tknIn           in   1                    1=IN token, 0=OUT token
//  i_tknOutNBytes    in   $clog2(MAX_PKT)+1    OUT data length
//  o_rspValid        out  1                    response available
//  i_rspReady        in   1                    response consumed
//  o_rspKind         out  2                    0=ACK(OUT) 1=DATA(IN) 2=NAK 3=STALL
//  o_rspPid1         out  1                    DATA PID: 1=DATA1, 0=DATA0
//  o_rspData         out  8*MAX_PKT            IN data, byte0 in [7:0]
//  o_rspData_nBytes  out  $clog2(MAX_PKT)+1    IN data length, 0..MAX_PKT
//  i_inAcked         in   1                    host ACKed last DATA response
//  o_romAddr         out  ROM_AW               ROM byte address
//  i_romData         in   8                    ROM data, 1-cycle read latency
//  o_devAddr         out  7                    current device address
//  o_configured      out  1                    configuration value 1 active
// BEHAVIOUR
//  Reset: FSM=IDLE. o_devAddr=0, o_configured=0, o_rspValid=0, o_romAddr=0,
//   o_rspData=0, nBytes=0, o_rspPid1=1.
//  FSM states: IDLE, FETCH, DATA_IN, STATUS_OUT, STATUS_IN, STALL.
//  SETUP decode: i_setupValid in any state aborts the current transfer, drops any
//   unconsumed response, and decodes the payload:
//   - bmRequestType=0x80, bRequest=6, wValue[15:8]=1 or 2 -> xferLen=min(wLength,
//     descLen); rem=xferLen; ptr=base; PID=DATA1; go to FETCH.
//   - 0x00, bRequest=5 (SET_ADDRESS) -> pendAddr=wValue[6:0]; go to STATUS_IN.
//   - 0x00, bRequest=9, wValue<=1 -> pendCfg=wValue[0]; go to STATUS_IN.
//   - Any other request -> STALL.
//  FETCH: reads n=min(MAX_PKT,rem) bytes. Address issued at cycle k, byte captured
//   at k+1 into lane k. Chunk is ready n+1 cycles after entry, then go to DATA_IN.
//   n=0 is a ZLP and enters DATA_IN immediately.
//  Token handshake:
//   - o_tknReady=!o_rspValid.
//   - Response is registered 1 cycle after token acceptance. It is held stable
//     until i_rspReady.
//   - An IN token in FETCH gets NAK.
//  DATA_IN:
//   - IN -> DATA, chunk, current PID.
//   - OUT (early status stage) -> ACK, go to IDLE.
//   - On i_inAcked: rem-=n, ptr+=n, PID toggles.
//     - If rem>0 -> FETCH.
//     - If rem==0 and last n==MAX_PKT and xferLen<wLength -> FETCH (ZLP).
//     - Otherwise -> STATUS_OUT.
//   - A repeated IN without i_inAcked retransmits the identical chunk and PID.
//  STATUS_OUT: IN -> NAK. OUT with 0 bytes -> ACK, go to IDLE. OUT with >0 bytes -> STALL.
//  STATUS_IN:
//   - IN -> DATA1 ZLP. OUT -> STALL.
//   - On i_inAcked: apply pendAddr to o_devAddr / pendCfg to o_configured in the
//     same edge, then go to IDLE. Never apply earlier.
//  STALL: every token gets STALL until the next SETUP.
//  IDLE: IN -> NAK, OUT -> ACK.
//  xferLen is 16b; the compare uses zero-extended descLen. rem and ptr never wrap:
//   ptr+rem<=base+descLen.
//  Reset asserted mid-transfer: immediate return to reset values, including o_devAddr=0.
// TESTING
//  1. GET_DESCRIPTOR DEVICE, wLength=18 -> INs return 8B DATA1, 8B DATA0, 2B DATA1
//     = ROM[0..17]; extra IN -> NAK; OUT 0B -> ACK.
//  2. GET_DESCRIPTOR CONFIG, wLength=0xFFFF, CFGDESC_LEN=32 -> 4x8B, then DATA1 ZLP;
//     further INs NAK until OUT 0B -> ACK.
//  3. GET_DESCRIPTOR DEVICE, wLength=10 -> 8B, then 2B; no ZLP.
//  4. SET_ADDRESS wValue=55 -> o_devAddr=0 through ZLP send; becomes 55 on i_inAcked.
//  5. GET_DESCRIPTOR STRING (wValue=0x0300) -> IN STALL, OUT STALL; next valid SETUP
//     clears the stall and serves normally.
//  6. IN with no i_inAcked -> same bytes and PID resent. SETUP mid-data aborts.
//     i_rst mid-data -> o_rspValid=0, o_devAddr=0, FSM=IDLE.

Source files
------------

// File: rtl/usbfs_ctrl_responder.sv
// usbfs_ctrl_responder
// Device-side responder for USB full-speed control endpoint 0.
// Decodes 8-byte SETUP payloads and serves GET_DESCRIPTOR data in MAX_PKT
// chunks read from an external descriptor ROM. Runs the status stages and
// applies SET_ADDRESS / SET_CONFIGURATION once the host has ACKed the status ZLP.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_setupValid/Data       SETUP payload from the transactor (byte0 in [7:0])
//   i_tknValid/o_tknReady   EP0 token handshake; i_tknIn selects IN vs OUT,
//                           i_tknOutNBytes is the OUT data length
//   o_rspValid/i_rspReady   registered response handshake
//   o_rspKind               0=ACK 1=DATA 2=NAK 3=STALL
//   o_rspPid1               DATA PID (1=DATA1)
//   o_rspData/_nBytes       IN payload and its length
//   i_inAcked               host ACKed the last DATA response
//   o_romAddr/i_romData     descriptor ROM port, 1-cycle read latency
//   o_devAddr, o_configured current address and configuration state
module usbfs_ctrl_responder #(
    parameter int MAX_PKT      = 8,
    parameter int ROM_AW       = 7,
    parameter int DEVDESC_BASE = 0,
    parameter int DEVDESC_LEN  = 18,
    parameter int CFGDESC_BASE = 18,
    parameter int CFGDESC_LEN  = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_setupValid,
    input  logic [63:0]               i_setupData,
    input  logic                      i_tknValid,
    output logic                      o_tknReady,
    input  logic                      i_tknIn,
    input  logic [$clog2(MAX_PKT):0]  i_tknOutNBytes,
    output logic                      o_rspValid,
    input  logic                      i_rspReady,
    output logic [1:0]                o_rspKind,
    output logic                      o_rspPid1,
    output logic [8*MAX_PKT-1:0]      o_rspData,
    output logic [$clog2(MAX_PKT):0]  o_rspData_nBytes,
    input  logic                      i_inAcked,
    output logic [ROM_AW-1:0]         o_romAddr,
    input  logic [7:0]                i_romData,
    output logic [6:0]                o_devAddr,
    output logic                      o_configured
);

    localparam int NB = $clog2(MAX_PKT) + 1;
    localparam logic [1:0] KIND_ACK   = 2'd0;
    localparam logic [1:0] KIND_DATA  = 2'd1;
    localparam logic [1:0] KIND_NAK   = 2'd2;
    localparam logic [1:0] KIND_STALL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DATA_IN, ST_STATUS_OUT, ST_STATUS_IN, ST_STALL
    } state_t;

    state_t state_q, state_d;

    logic [15:0]          xferLen_q, xferLen_d, wLength_q, wLength_d, rem_q, rem_d;
    logic [ROM_AW-1:0]    ptr_q, ptr_d;
    logic                 pid_q, pid_d;
    logic [NB-1:0]        cnt_q, cnt_d, chunkN_q, chunkN_d;
    logic [8*MAX_PKT-1:0] chunk_q, chunk_d;
    logic [6:0]           pendAddr_q, pendAddr_d, devAddr_q, devAddr_d;
    logic                 pendIsAddr_q, pendIsAddr_d, pendCfg_q, pendCfg_d;
    logic                 configured_q, configured_d;
    logic                 rspValid_q, rspValid_d, rspPid1_q, rspPid1_d;
    logic [1:0]           rspKind_q, rspKind_d;
    logic [8*MAX_PKT-1:0] rspData_q, rspData_d;
    logic [NB-1:0]        rspN_q, rspN_d;

    // SETUP field extraction; wIndex is not needed by any supported request.
    logic [7:0]  bmReqType, bRequest;
    logic [15:0] wValue, wLength;
    logic        unusedWIndex;
    assign bmReqType    = i_setupData[7:0];
    assign bRequest     = i_setupData[15:8];
    assign wValue       = i_setupData[31:16];
    assign wLength      = i_setupData[63:48];
    assign unusedWIndex = ^i_setupData[47:32];

    logic isGetDev, isGetCfg, isSetAddr, isSetCfg;
    assign isGetDev  = (bmReqType == 8'h80) && (bRequest == 8'd6) && (wValue[15:8] == 8'd1);
    assign isGetCfg  = (bmReqType == 8'h80) && (bRequest == 8'd6) && (wValue[15:8] == 8'd2);
    assign isSetAddr = (bmReqType == 8'h00) && (bRequest == 8'd5);
    assign isSetCfg  = (bmReqType == 8'h00) && (bRequest == 8'd9) && (wValue <= 16'd1);

    logic [15:0]       descLen, setupXferLen;
    logic [ROM_AW-1:0] descBase;
    assign descLen      = isGetCfg ? 16'(CFGDESC_LEN) : 16'(DEVDESC_LEN);
    assign descBase     = isGetCfg ? ROM_AW'(CFGDESC_BASE) : ROM_AW'(DEVDESC_BASE);
    assign setupXferLen = (wLength < descLen) ? wLength : descLen;

    // Size of the chunk being fetched; zero means a ZLP.
    logic [NB-1:0] chunkLen;
    assign chunkLen = (rem_q < 16'(MAX_PKT)) ? rem_q[NB-1:0] : NB'(MAX_PKT);

    logic        fetchDone, tknAccept, moreData;
    logic [15:0] ackRem;
    assign fetchDone = (state_q == ST_FETCH) && (cnt_q == chunkLen);
    // A SETUP in the same cycle wins; the token is swallowed by the abort.
    assign tknAccept = i_tknValid && !rspValid_q && !i_setupValid;
    assign ackRem    = rem_q - 16'(chunkN_q);
    // A full last packet that ends short of wLength must be followed by a ZLP.
    assign moreData  = (ackRem != 16'd0) ||
                       ((chunkN_q == NB'(MAX_PKT)) && (xferLen_q < wLength_q));

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a SETUP overrides whatever transfer is in progress.
    always_comb begin
        state_d = state_q;
        if (i_setupValid) begin
            if (isGetDev || isGetCfg)      state_d = ST_FETCH;
            else if (isSetAddr || isSetCfg) state_d = ST_STATUS_IN;
            else                            state_d = ST_STALL;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (tknAccept && !i_tknIn) state_d = ST_IDLE;
                    else if (fetchDone)        state_d = ST_DATA_IN;
                end
                ST_DATA_IN: begin
                    if (i_inAcked)                 state_d = moreData ? ST_FETCH : ST_STATUS_OUT;
                    else if (tknAccept && !i_tknIn) state_d = ST_IDLE;
                end
                ST_STATUS_OUT: begin
                    if (tknAccept && !i_tknIn)
                        state_d = (i_tknOutNBytes == '0) ? ST_IDLE : ST_STALL;
                end
                ST_STATUS_IN: begin
                    if (i_inAcked)                 state_d = ST_IDLE;
                    else if (tknAccept && !i_tknIn) state_d = ST_STALL;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Transfer datapath: ROM fetch, chunk accounting and deferred address/config.
    always_comb begin
        xferLen_d    = xferLen_q;
        wLength_d    = wLength_q;
        rem_d        = rem_q;
        ptr_d        = ptr_q;
        pid_d        = pid_q;
        cnt_d        = cnt_q;
        chunkN_d     = chunkN_q;
        chunk_d      = chunk_q;
        pendAddr_d   = pendAddr_q;
        pendIsAddr_d = pendIsAddr_q;
        pendCfg_d    = pendCfg_q;
        devAddr_d    = devAddr_q;
        configured_d = configured_q;
        if (i_setupValid) begin
            xferLen_d    = setupXferLen;
            wLength_d    = wLength;
            rem_d        = setupXferLen;
            ptr_d        = descBase;
            pid_d        = 1'b1;
            cnt_d        = '0;
            pendIsAddr_d = isSetAddr;
            if (isSetAddr) pendAddr_d = wValue[6:0];
            if (isSetCfg)  pendCfg_d  = wValue[0];
        end else if (state_q == ST_FETCH) begin
            // Byte addressed in cycle k arrives in cycle k+1 and lands in lane k.
            if (cnt_q == '0) chunk_d = '0;
            else             chunk_d[8*(int'(cnt_q) - 1) +: 8] = i_romData;
            if (fetchDone) chunkN_d = chunkLen;
            else           cnt_d    = cnt_q + NB'(1);
        end else if (state_q == ST_DATA_IN && i_inAcked) begin
            rem_d = ackRem;
            ptr_d = ptr_q + ROM_AW'(chunkN_q);
            pid_d = !pid_q;
            cnt_d = '0;
        end else if (state_q == ST_STATUS_IN && i_inAcked) begin
            if (pendIsAddr_q) devAddr_d    = pendAddr_q;
            else              configured_d = pendCfg_q;
        end
    end

    // Response outputs: built on token acceptance and held until consumed.
    always_comb begin
        rspValid_d = rspValid_q && !i_rspReady;
        rspKind_d  = rspKind_q;
        rspPid1_d  = rspPid1_q;
        rspData_d  = rspData_q;
        rspN_d     = rspN_q;
        if (i_setupValid) begin
            rspValid_d = 1'b0;
        end else if (tknAccept) begin
            rspValid_d = 1'b1;
            rspData_d  = '0;
            rspN_d     = '0;
            case (state_q)
                ST_IDLE, ST_FETCH: rspKind_d = i_tknIn ? KIND_NAK : KIND_ACK;
                ST_DATA_IN: begin
                    if (i_tknIn) begin
                        rspKind_d = KIND_DATA;
                        rspData_d = chunk_q;
                        rspN_d    = chunkN_q;
                        rspPid1_d = pid_q;
                    end else begin
                        rspKind_d = KIND_ACK;
                    end
                end
                ST_STATUS_OUT: begin
                    if (i_tknIn)                    rspKind_d = KIND_NAK;
                    else if (i_tknOutNBytes == '0)  rspKind_d = KIND_ACK;
                    else                            rspKind_d = KIND_STALL;
                end
                ST_STATUS_IN: begin
                    if (i_tknIn) begin
                        rspKind_d = KIND_DATA;
                        rspPid1_d = 1'b1;
                    end else begin
                        rspKind_d = KIND_STALL;
                    end
                end
                default: rspKind_d = KIND_STALL;
            endcase
        end
    end

    // Datapath and response registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            xferLen_q    <= '0;
            wLength_q    <= '0;
            rem_q        <= '0;
            ptr_q        <= '0;
            pid_q        <= 1'b1;
            cnt_q        <= '0;
            chunkN_q     <= '0;
            chunk_q      <= '0;
            pendAddr_q   <= '0;
            pendIsAddr_q <= 1'b0;
            pendCfg_q    <= 1'b0;
            devAddr_q    <= '0;
            configured_q <= 1'b0;
            rspValid_q   <= 1'b0;
            rspKind_q    <= KIND_ACK;
            rspPid1_q    <= 1'b1;
            rspData_q    <= '0;
            rspN_q       <= '0;
        end else begin
            xferLen_q    <= xferLen_d;
            wLength_q    <= wLength_d;
            rem_q        <= rem_d;
            ptr_q        <= ptr_d;
            pid_q        <= pid_d;
            cnt_q        <= cnt_d;
            chunkN_q     <= chunkN_d;
            chunk_q      <= chunk_d;
            pendAddr_q   <= pendAddr_d;
            pendIsAddr_q <= pendIsAddr_d;
            pendCfg_q    <= pendCfg_d;
            devAddr_q    <= devAddr_d;
            configured_q <= configured_d;
            rspValid_q   <= rspValid_d;
            rspKind_q    <= rspKind_d;
            rspPid1_q    <= rspPid1_d;
            rspData_q    <= rspData_d;
            rspN_q       <= rspN_d;
        end
    end

    assign o_tknReady       = !rspValid_q;
    assign o_rspValid       = rspValid_q;
    assign o_rspKind        = rspKind_q;
    assign o_rspPid1        = rspPid1_q;
    assign o_rspData        = rspData_q;
    assign o_rspData_nBytes = rspN_q;
    assign o_devAddr        = devAddr_q;
    assign o_configured     = configured_q;
    assign o_romAddr        = (state_q == ST_FETCH && cnt_q < chunkLen) ?
                              ptr_q + ROM_AW'(cnt_q) : '0;

endmodule

// File: tb/tb_usbfs_ctrl_responder.sv
// tb_usbfs_ctrl_responder
// Directed bench for usbfs_ctrl_responder: drives SETUPs and tokens at the
// falling edge, models the descriptor ROM and compares each response against
// hand-derived kinds, PIDs, lengths and ROM bytes.
module tb_usbfs_ctrl_responder;

    localparam logic [1:0] ACK = 2'd0, DATA = 2'd1, NAK = 2'd2, STALL = 2'd3;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_setupValid = 1'b0;
    logic [63:0] i_setupData = '0;
    logic        i_tknValid = 1'b0;
    logic        o_tknReady;
    logic        i_tknIn = 1'b0;
    logic [3:0]  i_tknOutNBytes = '0;
    logic        o_rspValid;
    logic        i_rspReady = 1'b0;
    logic [1:0]  o_rspKind;
    logic        o_rspPid1;
    logic [63:0] o_rspData;
    logic [3:0]  o_rspData_nBytes;
    logic        i_inAcked = 1'b0;
    logic [6:0]  o_romAddr;
    logic [7:0]  i_romData = '0;
    logic [6:0]  o_devAddr;
    logic        o_configured;

    logic [7:0]  rom [0:127];
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  rKind;
    logic        rPid;
    logic [63:0] rData;
    logic [3:0]  rN;

    usbfs_ctrl_responder dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_setupValid(i_setupValid), .i_setupData(i_setupData),
        .i_tknValid(i_tknValid), .o_tknReady(o_tknReady), .i_tknIn(i_tknIn),
        .i_tknOutNBytes(i_tknOutNBytes),
        .o_rspValid(o_rspValid), .i_rspReady(i_rspReady), .o_rspKind(o_rspKind),
        .o_rspPid1(o_rspPid1), .o_rspData(o_rspData), .o_rspData_nBytes(o_rspData_nBytes),
        .i_inAcked(i_inAcked), .o_romAddr(o_romAddr), .i_romData(i_romData),
        .o_devAddr(o_devAddr), .o_configured(o_configured)
    );

    always #5 i_clk = !i_clk;

    // Descriptor ROM with one cycle of read latency
    always @(posedge i_clk) i_romData <= rom[o_romAddr];

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [63:0] expChunk(input int base, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rom[base + i];
        return v;
    endfunction

    // SETUP then enough idle cycles for any following chunk fetch
    task automatic sendSetup(input logic [7:0] bm, input logic [7:0] req,
                             input logic [15:0] wVal, input logic [15:0] wLen);
        i_setupData  = {wLen, 16'h0000, wVal, req, bm};
        i_setupValid = 1'b1;
        @(negedge i_clk);
        i_setupValid = 1'b0;
        repeat (12) @(negedge i_clk);
    endtask

    task automatic hostAck();
        i_inAcked = 1'b1;
        @(negedge i_clk);
        i_inAcked = 1'b0;
        repeat (12) @(negedge i_clk);
    endtask

    // One token: wait for ready, present it, capture and consume the response
    task automatic applyStimulus(input logic isIn, input logic [3:0] nb);
        int waitCnt = 0;
        while (!o_tknReady && waitCnt < 20) begin
            @(negedge i_clk);
            waitCnt++;
        end
        if (!o_tknReady) checkOutput("tknReady timeout", 64'(o_tknReady), 64'd1);
        i_tknValid     = 1'b1;
        i_tknIn        = isIn;
        i_tknOutNBytes = nb;
        @(negedge i_clk);
        i_tknValid = 1'b0;
        waitCnt = 0;
        while (!o_rspValid && waitCnt < 20) begin
            @(negedge i_clk);
            waitCnt++;
        end
        if (!o_rspValid) checkOutput("rspValid timeout", 64'(o_rspValid), 64'd1);
        rKind = o_rspKind;
        rPid  = o_rspPid1;
        rData = o_rspData;
        rN    = o_rspData_nBytes;
        i_rspReady = 1'b1;
        @(negedge i_clk);
        i_rspReady = 1'b0;
    endtask

    task automatic expectData(input string tag, input logic pid, input int base, input int n);
        applyStimulus(1'b1, 4'd0);
        checkOutput({tag, " kind"}, 64'(rKind), 64'(DATA));
        checkOutput({tag, " pid"},  64'(rPid),  64'(pid));
        checkOutput({tag, " len"},  64'(rN),    64'(n));
        checkOutput({tag, " data"}, rData,      expChunk(base, n));
    endtask

    task automatic expectKind(input string tag, input logic isIn, input logic [3:0] nb,
                              input logic [1:0] kind);
        applyStimulus(isIn, nb);
        checkOutput(tag, 64'(rKind), 64'(kind));
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 8'((i * 37 + 11) & 8'hFF);

        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        $display("[TB] reset values");
        checkOutput("reset rspValid",   64'(o_rspValid),       64'd0);
        checkOutput("reset tknReady",   64'(o_tknReady),       64'd1);
        checkOutput("reset devAddr",    64'(o_devAddr),        64'd0);
        checkOutput("reset configured", 64'(o_configured),     64'd0);
        checkOutput("reset romAddr",    64'(o_romAddr),        64'd0);
        checkOutput("reset rspData",    o_rspData,             64'd0);
        checkOutput("reset nBytes",     64'(o_rspData_nBytes), 64'd0);
        checkOutput("reset pid",        64'(o_rspPid1),        64'd1);
        expectKind("idle IN", 1'b1, 4'd0, NAK);
        expectKind("idle OUT", 1'b0, 4'd0, ACK);

        $display("[TB] device descriptor, wLength=18");
        sendSetup(8'h80, 8'd6, 16'h0100, 16'd18);
        expectData("dev c0", 1'b1, 0, 8);
        hostAck();
        expectData("dev c1", 1'b0, 8, 8);
        hostAck();
        expectData("dev c2", 1'b1, 16, 2);
        hostAck();
        expectKind("dev status IN", 1'b1, 4'd0, NAK);
        expectKind("dev status OUT", 1'b0, 4'd0, ACK);
        expectKind("dev after IN", 1'b1, 4'd0, NAK);

        $display("[TB] config descriptor, wLength=0xFFFF");
        sendSetup(8'h80, 8'd6, 16'h0200, 16'hFFFF);
        for (int c = 0; c < 4; c++) begin
            expectData($sformatf("cfg c%0d", c), (c % 2 == 0), 18 + 8 * c, 8);
            hostAck();
        end
        expectData("cfg zlp", 1'b1, 0, 0);
        hostAck();
        expectKind("cfg status IN a", 1'b1, 4'd0, NAK);
        expectKind("cfg status IN b", 1'b1, 4'd0, NAK);
        expectKind("cfg status OUT", 1'b0, 4'd0, ACK);

        $display("[TB] device descriptor, wLength=10");
        sendSetup(8'h80, 8'd6, 16'h0100, 16'd10);
        expectData("short c0", 1'b1, 0, 8);
        hostAck();
        expectData("short c1", 1'b0, 8, 2);
        hostAck();
        expectKind("short no zlp", 1'b1, 4'd0, NAK);
        expectKind("short status OUT 3B", 1'b0, 4'd3, STALL);
        expectKind("short stalled IN", 1'b1, 4'd0, STALL);

        $display("[TB] set address / set configuration");
        sendSetup(8'h00, 8'd5, 16'd55, 16'd0);
        checkOutput("addr before zlp", 64'(o_devAddr), 64'd0);
        expectData("addr zlp", 1'b1, 0, 0);
        checkOutput("addr before ack", 64'(o_devAddr), 64'd0);
        hostAck();
        checkOutput("addr after ack", 64'(o_devAddr), 64'd55);
        expectKind("addr idle", 1'b1, 4'd0, NAK);
        sendSetup(8'h00, 8'd9, 16'd1, 16'd0);
        expectData("cfg set zlp", 1'b1, 0, 0);
        checkOutput("cfg before ack", 64'(o_configured), 64'd0);
        hostAck();
        checkOutput("cfg after ack", 64'(o_configured), 64'd1);
        sendSetup(8'h00, 8'd9, 16'd2, 16'd0);
        expectKind("bad cfg value", 1'b1, 4'd0, STALL);

        $display("[TB] unsupported string descriptor");
        sendSetup(8'h80, 8'd6, 16'h0300, 16'd255);
        expectKind("string IN", 1'b1, 4'd0, STALL);
        expectKind("string OUT", 1'b0, 4'd0, STALL);
        sendSetup(8'h80, 8'd6, 16'h0100, 16'd8);
        expectData("recover c0", 1'b1, 0, 8);
        hostAck();
        expectKind("recover status IN", 1'b1, 4'd0, NAK);
        expectKind("recover status OUT", 1'b0, 4'd0, ACK);

        $display("[TB] retransmit, abort, reset");
        sendSetup(8'h80, 8'd6, 16'h0100, 16'd18);
        expectData("retx first", 1'b1, 0, 8);
        expectData("retx again", 1'b1, 0, 8);
        hostAck();
        expectData("retx next", 1'b0, 8, 8);
        sendSetup(8'h80, 8'd6, 16'h0100, 16'd18);
        expectData("abort restart", 1'b1, 0, 8);
        checkOutput("addr still set", 64'(o_devAddr), 64'd55);
        i_tknValid = 1'b1;
        i_tknIn    = 1'b1;
        @(negedge i_clk);
        i_tknValid = 1'b0;
        checkOutput("pending rsp", 64'(o_rspValid), 64'd1);
        i_rst = 1'b1;
        #1;
        checkOutput("rst rspValid", 64'(o_rspValid), 64'd0);
        checkOutput("rst devAddr", 64'(o_devAddr), 64'd0);
        checkOutput("rst configured", 64'(o_configured), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        expectKind("rst idle IN", 1'b1, 4'd0, NAK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
